regs_bank_ctl: RTL and testbench

- Parametrised successor to the fixed X/Y/S register bus control: register storage, SB bus source/destination control and stack-pointer arithmetic in one block.
- NREGS index registers plus stack pointer S, all W bits wide.
- Two-stage pipeline: decode latch, then execute. A ready stall freezes the execute stage.
- Sits between the instruction decoder and the internal SB/ADL buses of the CPU core.

---
 rtl/regs_bank_ctl.sv | 87 ++++++++
 tb/tb_regs_bank_ctl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/regs_bank_ctl.sv
// regs_bank_ctl: index/stack register bank with SB/ADL bus control and a one-deep execute stage.
// Optional sticky stack-bound flag enabled by defining REGS_BANK_STK_BOUND_EN.
module regs_bank_ctl #(
  parameter int W = 8,
  parameter int NREGS = 2,
  parameter int SELW = 2,
  parameter logic [W-1:0] S_INIT = W'(8'hFD)
) (
  input  logic            PHI0,
  input  logic            n_RES,
  input  logic            n_ready,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [SELW-1:0] cmd_src,
  input  logic [SELW-1:0] cmd_dst,
  input  logic [1:0]      cmd_stk,
  input  logic [W-1:0]    sb_in,
  output logic [W-1:0]    sb_out,
  output logic            sb_drive,
  output logic [W-1:0]    adl_out,
  output logic            s_adl,
  output logic            stxy,
  output logic            stk_ovf
);
  typedef enum logic [1:0] {IDLE, EXEC, STALL} state_t;
  localparam logic [SELW-1:0] S_SEL = SELW'(NREGS + 1);
  state_t state;
  logic [SELW-1:0] src, dst;
  logic [1:0] stk;
  logic [W-1:0] xr [NREGS];
  logic [W-1:0] s, src_val, wr_val, s_nxt;
  logic busy, commit, accept, src_idx, src_s, src_int, src_ok, dst_s, push, pop;
  assign busy    = state != IDLE;
  assign cmd_ready = ~(busy & n_ready);
  assign accept  = cmd_valid & cmd_ready;
  assign commit  = busy & ~n_ready;
  assign src_idx = src != '0 && src < S_SEL;
  assign src_s   = src == S_SEL;
  assign src_int = src_idx | src_s;
  // a selector above S is "none": it drives nothing and writes nothing
  assign src_ok  = src_int | src == '0;
  assign dst_s   = dst == S_SEL;
  assign push    = stk == 2'b01;
  assign pop     = stk == 2'b10;
  always_comb begin
    src_val = src_s ? s : '0;
    for (int i = 0; i < NREGS; i++) src_val = src == SELW'(i + 1) ? xr[i] : src_val;
  end
  assign wr_val   = src_int ? src_val : sb_in;
  // a write to S takes priority; the concurrent push/pop is dropped
  assign s_nxt    = dst_s ? (src_ok ? wr_val : s) : push ? s - W'(1) : pop ? s + W'(1) : s;
  assign sb_drive = busy & src_int;
  assign sb_out   = sb_drive ? src_val : '0;
  assign s_adl    = busy & (push | pop);
  assign adl_out  = s;
  assign stxy     = busy & src_idx & dst == '0;
  always_ff @(posedge PHI0 or negedge n_RES) begin
    if (!n_RES) begin
      state <= IDLE;
      src <= '0;
      dst <= '0;
      stk <= '0;
      s <= S_INIT;
      for (int i = 0; i < NREGS; i++) xr[i] <= '0;
    end else begin
      state <= accept ? EXEC : (state == EXEC && n_ready) ? STALL : commit ? IDLE : state;
      if (accept) begin
        src <= cmd_src;
        dst <= cmd_dst;
        stk <= cmd_stk;
      end
      if (commit) s <= s_nxt;
      for (int i = 0; i < NREGS; i++)
        if (commit && src_ok && dst == SELW'(i + 1)) xr[i] <= wr_val;
    end
  end
`ifdef REGS_BANK_STK_BOUND_EN
  logic ovf;
  always_ff @(posedge PHI0 or negedge n_RES) begin
    if (!n_RES) ovf <= 1'b0;
    else if (commit && !dst_s && ((push && s == '0) || (pop && s == '1))) ovf <= 1'b1;
  end
  assign stk_ovf = ovf;
`else
  assign stk_ovf = 1'b0;
`endif
endmodule

// File: tb/tb_regs_bank_ctl.sv
// tb_regs_bank_ctl: table-driven vectors with an expected-output queue for regs_bank_ctl.
module tb_regs_bank_ctl;
  typedef struct packed {
    logic       drv;
    logic [7:0] sb;
    logic       sadl;
    logic [7:0] adl;
    logic       stxy;
  } exp_t;
  typedef struct {
    logic [1:0] src, dst, stk;
    logic [7:0] sb;
    exp_t       e;
  } vec_t;
`ifdef REGS_BANK_STK_BOUND_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif
  logic PHI0 = 0, n_RES = 0, n_ready = 0, cmd_valid = 0;
  logic cmd_ready, sb_drive, s_adl, stxy, stk_ovf;
  logic [1:0] cmd_src = 0, cmd_dst = 0, cmd_stk = 0;
  logic [7:0] sb_in = 0, sb_out, adl_out;
  int total = 0, bad = 0;
  exp_t q[$];
  vec_t tbl[15];
  localparam exp_t NONE = '0;

  regs_bank_ctl dut (
    .PHI0(PHI0), .n_RES(n_RES), .n_ready(n_ready), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_stk(cmd_stk), .sb_in(sb_in), .sb_out(sb_out),
    .sb_drive(sb_drive), .adl_out(adl_out), .s_adl(s_adl), .stxy(stxy), .stk_ovf(stk_ovf)
  );

  always #5 PHI0 = ~PHI0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] sr, ds, sk, input logic [7:0] sb,
                              input logic drv, input logic [7:0] sbo, input logic sadl,
                              input logic [7:0] adl, input logic sx);
    vec_t v;
    v.src = sr; v.dst = ds; v.stk = sk; v.sb = sb;
    v.e = '{drv: drv, sb: sbo, sadl: sadl, adl: adl, stxy: sx};
    return v;
  endfunction

  // drive on the falling edge, check the execute stage just after, commit/accept on the next rising edge
  task automatic step(input logic v, input logic [1:0] sr, ds, sk, input logic [7:0] sb,
                      input logic nr, input exp_t e);
    logic rdy;
    @(negedge PHI0);
    cmd_valid = v; cmd_src = sr; cmd_dst = ds; cmd_stk = sk; sb_in = sb; n_ready = nr;
    #1;
    rdy = !(q.size() > 0 && nr);
    chk("cmd_ready", cmd_ready, rdy);
    if (q.size() > 0) begin
      chk("sb_drive", sb_drive, q[0].drv);
      chk("sb_out", sb_out, q[0].sb);
      chk("s_adl", s_adl, q[0].sadl);
      chk("adl_out", adl_out, q[0].adl);
      chk("stxy", stxy, q[0].stxy);
      if (!nr) void'(q.pop_front());
    end else begin
      chk("idle_drive", {sb_drive, s_adl, stxy}, 3'b000);
    end
    if (v && rdy) q.push_back(e);
  endtask

  initial begin
    tbl[0]  = mk(0, 1, 0, 8'h5A, 0, 8'h00, 0, 8'hFD, 0);
    tbl[1]  = mk(1, 2, 0, 8'h00, 1, 8'h5A, 0, 8'hFD, 0);
    tbl[2]  = mk(2, 0, 0, 8'h00, 1, 8'h5A, 0, 8'hFD, 1);
    tbl[3]  = mk(3, 0, 1, 8'h00, 1, 8'hFD, 1, 8'hFD, 0);
    tbl[4]  = mk(3, 0, 0, 8'h00, 1, 8'hFC, 0, 8'hFC, 0);
    tbl[5]  = mk(0, 3, 0, 8'hFF, 0, 8'h00, 0, 8'hFC, 0);
    tbl[6]  = mk(0, 0, 2, 8'h00, 0, 8'h00, 1, 8'hFF, 0);
    tbl[7]  = mk(3, 1, 1, 8'h00, 1, 8'h00, 1, 8'h00, 0);
    tbl[8]  = mk(1, 0, 0, 8'h00, 1, 8'h00, 0, 8'hFF, 1);
    tbl[9]  = mk(0, 3, 0, 8'h40, 0, 8'h00, 0, 8'hFF, 0);
    tbl[10] = mk(0, 3, 1, 8'h80, 0, 8'h00, 1, 8'h40, 0);
    tbl[11] = mk(3, 2, 0, 8'h00, 1, 8'h80, 0, 8'h80, 0);
    tbl[12] = mk(2, 2, 0, 8'h00, 1, 8'h80, 0, 8'h80, 0);
    tbl[13] = mk(2, 0, 0, 8'h00, 1, 8'h80, 0, 8'h80, 1);
    tbl[14] = mk(0, 0, 3, 8'h00, 0, 8'h00, 0, 8'h80, 0);
    repeat (2) @(negedge PHI0);
    #1;
    chk("rst_sb_out", sb_out, 8'h00);
    chk("rst_sb_drive", sb_drive, 1'b0);
    chk("rst_s_adl", s_adl, 1'b0);
    chk("rst_stxy", stxy, 1'b0);
    chk("rst_stk_ovf", stk_ovf, 1'b0);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_adl_out", adl_out, 8'hFD);
    @(negedge PHI0) n_RES = 1;
    // back-to-back table, sb_in of entry i is presented while it executes
    for (int i = 0; i <= 15; i++)
      step(i < 15, i < 15 ? tbl[i].src : 2'd0, i < 15 ? tbl[i].dst : 2'd0,
           i < 15 ? tbl[i].stk : 2'd0, i > 0 ? tbl[i-1].sb : 8'h00, 0,
           i < 15 ? tbl[i].e : NONE);
    #1 chk("stk_ovf_sticky", stk_ovf, OVF_EXP);
    // stall on a read of X: outputs hold, a presented command is refused
    step(1, 0, 1, 0, 8'h00, 0, '{0, 8'h00, 0, 8'h80, 0});
    step(1, 1, 0, 0, 8'hA5, 0, '{1, 8'hA5, 0, 8'h80, 1});
    repeat (3) step(1, 0, 2, 0, 8'h00, 1, NONE);
    step(0, 0, 0, 0, 8'h00, 0, NONE);
    // stalled write to Y samples sb_in only at the commit edge
    step(1, 0, 2, 0, 8'h00, 0, '{0, 8'h00, 0, 8'h80, 0});
    repeat (2) step(0, 0, 0, 0, 8'h22, 1, NONE);
    step(0, 0, 0, 0, 8'h33, 0, NONE);
    step(1, 2, 0, 0, 8'h00, 0, '{1, 8'h33, 0, 8'h80, 1});
    step(0, 0, 0, 0, 8'h00, 0, NONE);
    // reset while a write to X is stalled
    step(1, 0, 1, 0, 8'h77, 0, '{0, 8'h00, 0, 8'h80, 0});
    step(0, 0, 0, 0, 8'h77, 1, NONE);
    #2 n_RES = 0;
    #1;
    chk("mid_rst_sb_drive", sb_drive, 1'b0);
    chk("mid_rst_sb_out", sb_out, 8'h00);
    chk("mid_rst_cmd_ready", cmd_ready, 1'b1);
    chk("mid_rst_adl_out", adl_out, 8'hFD);
    chk("mid_rst_stk_ovf", stk_ovf, 1'b0);
    #2 n_RES = 1;
    q.delete();
    step(1, 1, 0, 0, 8'h77, 0, '{1, 8'h00, 0, 8'hFD, 1});
    step(1, 2, 0, 0, 8'h77, 0, '{1, 8'h00, 0, 8'hFD, 1});
    step(0, 0, 0, 0, 8'h00, 0, NONE);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
